// File: rtl/clk_div_meas_if.sv
// Measurement result bundle of clk_div_meas: the recovered period/high time
// plus the valid pulse and the lock/timeout status flags.
interface clk_div_meas_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  modport master (output period, high_time, meas_valid, locked, timeout);
  modport slave  (input  period, high_time, meas_valid, locked, timeout);
endinterface

// File: rtl/clk_div_meas.sv
// Measures an asynchronous divided clock against clk_ref: recovers period and
// high time in reference cycles, flags lock after LOCK_N identical results.
module clk_div_meas #(
  parameter int CNT_W       = 16,
  parameter int LOCK_N      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_ref,
  input  logic            arst_n,
  input  logic            clk_in,
  clk_div_meas_if.master  meas
);

  localparam logic [CNT_W-1:0] CMAX   = '1;
  localparam logic [3:0]       LOCK_M = 4'(LOCK_N);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise;
  logic [CNT_W-1:0]       cnt, hcnt;
  logic [CNT_W-1:0]       period, high_time;
  logic                   meas_valid, locked, timeout;
  logic [3:0]             match, match_nxt;
  logic                   sat, take, drop;

  // clk_in is asynchronous: plain flop chain, no logic between stages
  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_in};
      s_d  <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign sat  = ~rise & (cnt == CMAX);

  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (rise)             cnt <= CNT_W'(1);
      else if (cnt != CMAX) cnt <= cnt + 1'b1;
      if (rise)                   hcnt <= CNT_W'(1);
      else if (s && hcnt != CMAX) hcnt <= hcnt + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = ARMED;
      ARMED:   if (sat)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (take a measurement / abandon on timeout)
  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    case (state)
      ARMED: begin
        take = rise;
        drop = sat;
      end
      default: ;
    endcase
  end

  // match == 0 only after reset or a timeout, i.e. first measurement of a run
  always_comb begin
    match_nxt = 4'd1;
    if (match != 4'd0 && cnt == period && hcnt == high_time)
      match_nxt = (match == LOCK_M) ? match : match + 4'd1;
  end

  always_ff @(posedge clk_ref or negedge arst_n) begin
    if (!arst_n) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      match      <= 4'd0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= take;
      if (take) begin
        period    <= cnt;
        high_time <= hcnt;
        match     <= match_nxt;
        locked    <= (match_nxt == LOCK_M);
      end else if (drop) begin
        match  <= 4'd0;
        locked <= 1'b0;
      end
      if (rise)     timeout <= 1'b0;
      else if (sat) timeout <= 1'b1;
    end
  end

  assign meas.period     = period;
  assign meas.high_time  = high_time;
  assign meas.meas_valid = meas_valid;
  assign meas.locked     = locked;
  assign meas.timeout    = timeout;

endmodule

// File: tb/tb_clk_div_meas.sv
// Directed bench for clk_div_meas: table of divide ratios on a 16-bit
// instance, hand sequences for ratio switch, reset, and timeouts (CNT_W=4).
module tb_clk_div_meas;

  logic clk_ref = 1'b0;
  logic arst_n  = 1'b0;
  logic arst4_n = 1'b0;
  logic clk16   = 1'b0;
  logic clk4    = 1'b0;

  always #5 clk_ref = ~clk_ref;

  clk_div_meas_if #(.CNT_W(16)) if16 ();
  clk_div_meas_if #(.CNT_W(4))  if4 ();

  clk_div_meas #(.CNT_W(16), .LOCK_N(4), .SYNC_STAGES(2)) dut16 (
    .clk_ref(clk_ref), .arst_n(arst_n), .clk_in(clk16), .meas(if16)
  );
  clk_div_meas #(.CNT_W(4), .LOCK_N(4), .SYNC_STAGES(2)) dut4 (
    .clk_ref(clk_ref), .arst_n(arst4_n), .clk_in(clk4), .meas(if4)
  );

  typedef struct {
    int div;
    int hi;
    int cycles;
    int exp_period;
    int exp_high;
  } vec_t;

  int npass = 0;
  int ntot  = 0;

  // per-run statistics filled by run16
  int r_nmeas, r_nbad, r_first_step, r_lock_idx, r_drops, r_spacing_bad;
  int r_lk_first_good, r_last_step;

  task automatic chk(input string name, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic reset16();
    @(negedge clk_ref);
    clk16  = 1'b0;
    arst_n = 1'b0;
    @(negedge clk_ref);
    @(posedge clk_ref);
    #2 arst_n = 1'b1;
  endtask

  // Drive clk16 as a synchronous /div pattern high for hi cycles, starting
  // with a rising edge; sample the DUT on each falling edge before driving.
  task automatic run16(input int div, input int hi, input int cycles,
                       input int ep, input int eh);
    int ph = 0;
    r_nmeas = 0; r_nbad = 0; r_first_step = -1; r_lock_idx = 0;
    r_drops = 0; r_spacing_bad = 0; r_lk_first_good = -1; r_last_step = -1;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk_ref);
      if (if16.meas_valid) begin
        if (r_first_step < 0) r_first_step = j;
        if (int'(if16.period) == ep && int'(if16.high_time) == eh) begin
          r_nmeas++;
          if (r_lk_first_good < 0) r_lk_first_good = int'(if16.locked);
          if (if16.locked && r_lock_idx == 0) r_lock_idx = r_nmeas;
        end else begin
          r_nbad++;
        end
        if (r_last_step >= 0 && j - r_last_step != div) r_spacing_bad++;
        r_last_step = j;
      end
      if (r_lock_idx != 0 && !if16.locked) r_drops++;
      clk16 = (ph < hi);
      ph    = (ph + 1) % div;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int to_step, mv_cnt, lk_ever;
    logic lk_at_to;

    vecs[0] = '{4, 2, 100, 4, 2};
    vecs[1] = '{3, 1, 40,  3, 1};
    vecs[2] = '{3, 2, 40,  3, 2};
    vecs[3] = '{6, 3, 60,  6, 3};
    vecs[4] = '{5, 2, 50,  5, 2};
    vecs[5] = '{8, 6, 64,  8, 6};

    // reset state, before any clock edge
    #1;
    chk("rst_period",     if16.period,     0);
    chk("rst_high_time",  if16.high_time,  0);
    chk("rst_meas_valid", if16.meas_valid, 0);
    chk("rst_locked",     if16.locked,     0);
    chk("rst_timeout",    if16.timeout,    0);
    chk("rst4_period",    if4.period,      0);
    chk("rst4_timeout",   if4.timeout,     0);

    // table: measurement begins at the 2nd rise (drive + 3 sampled cycles)
    for (int v = 0; v < 6; v++) begin
      reset16();
      run16(vecs[v].div, vecs[v].hi, vecs[v].cycles,
            vecs[v].exp_period, vecs[v].exp_high);
      chk($sformatf("v%0d_first_meas_step", v), r_first_step, vecs[v].div + 3);
      chk($sformatf("v%0d_bad_values", v), r_nbad, 0);
      chk($sformatf("v%0d_meas_count", v), r_nmeas,
          (vecs[v].cycles - 1 - (vecs[v].div + 3)) / vecs[v].div + 1);
      chk($sformatf("v%0d_lock_at_meas", v), r_lock_idx, 4);
      chk($sformatf("v%0d_locked_first", v), r_lk_first_good, 0);
      chk($sformatf("v%0d_lock_drops", v), r_drops, 0);
      chk($sformatf("v%0d_spacing", v), r_spacing_bad, 0);
    end

    // ratio switch /4 -> /6: one carried-over (4,2) result, then relock
    reset16();
    run16(4, 2, 40, 4, 2);
    chk("sw_lock4_idx", r_lock_idx, 4);
    chk("sw_locked4_end", if16.locked, 1);
    run16(6, 3, 60, 6, 3);
    chk("sw_carry_meas", r_nbad, 1);
    chk("sw_unlock_first6", r_lk_first_good, 0);
    chk("sw_relock_idx", r_lock_idx, 4);
    chk("sw_spacing", r_spacing_bad, 0);
    chk("sw_locked6_end", if16.locked, 1);

    // asynchronous reset mid-run, 12 ns spanning a clock edge
    @(posedge clk_ref);
    #2 arst_n = 1'b0;
    clk16 = 1'b0;
    #1;
    chk("mid_rst_period",     if16.period,     0);
    chk("mid_rst_high_time",  if16.high_time,  0);
    chk("mid_rst_meas_valid", if16.meas_valid, 0);
    chk("mid_rst_locked",     if16.locked,     0);
    chk("mid_rst_timeout",    if16.timeout,    0);
    #11 arst_n = 1'b1;
    run16(4, 2, 20, 4, 2);
    chk("mid_rst_first_meas", r_first_step, 7);
    chk("mid_rst_bad", r_nbad, 0);

    // CNT_W=4: /4 lock, 20 cycles low -> timeout, then resume /4
    @(posedge clk_ref);
    #2 arst4_n = 1'b1;
    to_step = -1;
    lk_at_to = 1'b1;
    mv_cnt = 0;
    for (int j = 0; j < 56; j++) begin
      @(negedge clk_ref);
      if (j == 24) chk("to_locked_before", if4.locked, 1);
      if (if4.timeout && to_step < 0) begin
        to_step  = j;
        lk_at_to = if4.locked;
      end
      if (j == 46) chk("to_still_set", if4.timeout, 1);
      if (j == 47) chk("to_cleared_by_rise", if4.timeout, 0);
      if (j >= 44 && j <= 50 && if4.meas_valid) mv_cnt++;
      if (j == 51) begin
        chk("to_resume_meas_valid", if4.meas_valid, 1);
        chk("to_resume_period", if4.period, 4);
        chk("to_resume_high", if4.high_time, 2);
      end
      if (j < 24 || j >= 44) clk4 = ((j % 4) < 2);
      else                   clk4 = 1'b0;
    end
    chk("to_assert_step", to_step, 38);
    chk("to_locked_cleared", lk_at_to, 0);
    chk("to_no_meas_first_rise", mv_cnt, 0);

    // CNT_W=4: clk_in tied high from reset
    @(negedge clk_ref);
    arst4_n = 1'b0;
    clk4 = 1'b1;
    @(negedge clk_ref);
    @(posedge clk_ref);
    #2 arst4_n = 1'b1;
    to_step = -1;
    mv_cnt = 0;
    lk_ever = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk_ref);
      if (if4.timeout && to_step < 0) to_step = j;
      if (if4.meas_valid) mv_cnt++;
      if (if4.locked) lk_ever++;
    end
    chk("hi_timeout_step", to_step, 18);
    chk("hi_timeout_sticky", if4.timeout, 1);
    chk("hi_no_meas", mv_cnt, 0);
    chk("hi_no_lock", lk_ever, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
